// File: rtl/result_argmax_reader_if.sv
// Valid/ready result-word stream from the argmax reader to its downstream consumer.
// The master drives data/valid/last and the slave returns ready.
interface result_argmax_reader_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/result_argmax_reader.sv
// Reads the accelerator's output-layer words after `finished` rises, streams them out and
// tracks the signed argmax (lowest index wins on ties).
module result_argmax_reader #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RAM_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  finished,
  input  logic [ADDR_W-1:0]     result_base_address,
  input  logic [ADDR_W-1:0]     result_word_count,
  output logic [ADDR_W-1:0]     ram_rd_adr,
  input  logic [DATA_W-1:0]     ram_rd_data,
  result_argmax_reader_if.master stream,
  output logic [ADDR_W-1:0]     argmax_idx,
  output logic [DATA_W-1:0]     argmax_val,
  output logic                  busy,
  output logic                  done
);

  if (RAM_RD_LAT < 1 || RAM_RD_LAT > 4) begin : g_bad_lat
    $error("RAM_RD_LAT must be in 1..4");
  end

  localparam logic [DATA_W-1:0] MostNeg = {1'b1, {(DATA_W - 1){1'b0}}};
  localparam logic [2:0]        LatInit = 3'(RAM_RD_LAT);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StHold,
    StDone
  } state_e;

  state_e              state_q;
  logic                finished_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   count_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   last_idx;
  logic [2:0]          lat_q;
  logic [ADDR_W-1:0]   rd_adr_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                last_q;
  logic [ADDR_W-1:0]   am_idx_q;
  logic [DATA_W-1:0]   am_val_q;
  logic                busy_q;
  logic                done_q;

  // Only meaningful while a run with count >= 1 is in progress.
  assign last_idx = count_q - ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      // Treat finished as already high so a level held across reset cannot start a run.
      finished_q <= 1'b1;
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
      rd_adr_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      am_idx_q   <= '0;
      am_val_q   <= MostNeg;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      finished_q <= finished;
      unique case (state_q)
        StIdle: begin
          if (finished && !finished_q) begin
            base_q   <= result_base_address;
            count_q  <= result_word_count;
            idx_q    <= '0;
            am_idx_q <= '0;
            am_val_q <= MostNeg;
            if (result_word_count == '0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              busy_q  <= 1'b1;
              state_q <= StAddr;
            end
          end
        end

        StAddr: begin
          rd_adr_q <= base_q + idx_q;
          lat_q    <= LatInit;
          state_q  <= StWait;
        end

        StWait: begin
          if (lat_q <= 3'd1) begin
            lat_q   <= '0;
            data_q  <= ram_rd_data;
            valid_q <= 1'b1;
            last_q  <= (idx_q == last_idx);
            // Strict compare keeps the lowest index on ties; word 0 always seeds the max.
            if (idx_q == '0 || $signed(ram_rd_data) > $signed(am_val_q)) begin
              am_idx_q <= idx_q;
              am_val_q <= ram_rd_data;
            end
            state_q <= StHold;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end

        StHold: begin
          if (stream.ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (idx_q == last_idx) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= StAddr;
            end
          end
        end

        StDone: begin
          if (!finished) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign ram_rd_adr   = rd_adr_q;
  assign stream.data  = data_q;
  assign stream.valid = valid_q;
  assign stream.last  = last_q;
  assign argmax_idx   = am_idx_q;
  assign argmax_val   = am_val_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_result_argmax_reader.sv
// Directed bench for result_argmax_reader: a combinational neuron-RAM model, a word
// scoreboard checked every cycle, and a high-level argmax model pinned by literals.
module tb_result_argmax_reader;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 8;
  localparam int unsigned LAT = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          finished = 1'b0;
  logic [AW-1:0] base_in = '0;
  logic [AW-1:0] cnt_in = '0;
  logic [AW-1:0] ram_rd_adr;
  logic [DW-1:0] ram_rd_data;
  logic [AW-1:0] argmax_idx;
  logic [DW-1:0] argmax_val;
  logic          busy;
  logic          done;
  logic [DW-1:0] mem [256];

  result_argmax_reader_if #(.DATA_W(DW)) stream ();

  result_argmax_reader #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .RAM_RD_LAT(LAT)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .finished           (finished),
    .result_base_address(base_in),
    .result_word_count  (cnt_in),
    .ram_rd_adr         (ram_rd_adr),
    .ram_rd_data        (ram_rd_data),
    .stream             (stream),
    .argmax_idx         (argmax_idx),
    .argmax_val         (argmax_val),
    .busy               (busy),
    .done               (done)
  );

  assign ram_rd_data = mem[ram_rd_adr];

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] q_data [$];
  logic          q_last [$];
  logic [AW-1:0] q_adr [$];
  logic [AW-1:0] seen_adr [$];
  int            hs_count = 0;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          hold_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle scoreboard on the falling edge: word content, address, and hold stability.
  task automatic compare();
    if (!reset) begin
      hold_prev = 1'b0;
      return;
    end
    if (hold_prev) begin
      check("stable_valid", 32'(stream.valid), 32'd1);
      check("stable_data", 32'(stream.data), 32'(hold_data));
      check("stable_last", 32'(stream.last), 32'(hold_last));
    end
    if (stream.valid) begin
      if (q_data.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got %0h, expected no word", stream.data);
      end else begin
        check("word_data", 32'(stream.data), 32'(q_data[0]));
        check("word_last", 32'(stream.last), 32'(q_last[0]));
        check("rd_adr", 32'(ram_rd_adr), 32'(q_adr[0]));
      end
      if (stream.ready) begin
        if (q_data.size() != 0) begin
          void'(q_data.pop_front());
          void'(q_last.pop_front());
          void'(q_adr.pop_front());
        end
        seen_adr.push_back(ram_rd_adr);
        hs_count++;
        hold_prev = 1'b0;
      end else begin
        hold_prev = 1'b1;
        hold_data = stream.data;
        hold_last = stream.last;
      end
    end else begin
      hold_prev = 1'b0;
    end
  endtask

  always @(negedge clk) compare();

  // Argmax model: find the maximum signed value, then the first index holding it.
  task automatic model_argmax(input logic [AW-1:0] b, input logic [AW-1:0] c,
                              output logic [AW-1:0] idx, output logic [DW-1:0] val);
    int maxv;
    maxv = -128;
    idx  = '0;
    val  = 8'h80;
    for (int k = 0; k < int'(c); k++) begin
      if (int'($signed(mem[8'(int'(b) + k)])) > maxv) maxv = int'($signed(mem[8'(int'(b) + k)]));
    end
    for (int k = int'(c) - 1; k >= 0; k--) begin
      if (int'($signed(mem[8'(int'(b) + k)])) == maxv) begin
        idx = 8'(k);
        val = mem[8'(int'(b) + k)];
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_adr"}, 32'(ram_rd_adr), 32'h0);
    check({tag, "_out_data"}, 32'(stream.data), 32'h0);
    check({tag, "_out_valid"}, 32'(stream.valid), 32'h0);
    check({tag, "_out_last"}, 32'(stream.last), 32'h0);
    check({tag, "_argmax_idx"}, 32'(argmax_idx), 32'h0);
    check({tag, "_argmax_val"}, 32'(argmax_val), 32'h80);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // One run: return to idle, raise finished, steer ready, then check completion and argmax.
  task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] c, input int stall_word,
                     input int stall_cycles, input int abort_word);
    int            first_valid;
    int            done_cycle;
    int            stall_left;
    logic [AW-1:0] exp_idx;
    logic [DW-1:0] exp_val;
    finished = 1'b0;
    stream.ready = 1'b1;
    base_in = b;
    cnt_in = c;
    @(posedge clk); #1;
    @(posedge clk); #1;
    q_data.delete();
    q_last.delete();
    q_adr.delete();
    seen_adr.delete();
    hs_count = 0;
    for (int k = 0; k < int'(c); k++) begin
      q_data.push_back(mem[8'(int'(b) + k)]);
      q_last.push_back(k == int'(c) - 1);
      q_adr.push_back(8'(int'(b) + k));
    end
    finished    = 1'b1;
    first_valid = -1;
    done_cycle  = -1;
    stall_left  = stall_cycles;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) check("busy_after_start", 32'(busy), 32'(c != 0));
      if (stream.valid && first_valid < 0) first_valid = cyc;
      if (abort_word >= 0 && stream.valid && hs_count == abort_word) begin
        stream.ready = 1'b0;
        reset = 1'b0;
        finished = 1'b0;
        @(posedge clk); #1;
        check_reset_values("abort");
        q_data.delete();
        q_last.delete();
        q_adr.delete();
        reset = 1'b1;
        stream.ready = 1'b1;
        return;
      end
      if (stream.valid && hs_count == stall_word && stall_left > 0) begin
        stream.ready = 1'b0;
        stall_left--;
      end else begin
        stream.ready = 1'b1;
      end
      if (done) begin
        done_cycle = cyc;
        break;
      end
    end
    check("done_reached", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    check("words_drained", 32'(q_data.size()), 32'd0);
    check("words_emitted", 32'(hs_count), 32'(c));
    if (c == 0) begin
      check("count0_no_word", 32'(first_valid < 0), 32'd1);
      check("count0_done_latency", 32'(done_cycle >= 1 && done_cycle <= 2), 32'd1);
    end else begin
      check("first_word_latency", 32'(first_valid), 32'(2 + LAT));
    end
    model_argmax(b, c, exp_idx, exp_val);
    check("argmax_idx_model", 32'(argmax_idx), 32'(exp_idx));
    check("argmax_val_model", 32'(argmax_val), 32'(exp_val));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = '0;
    mem[8'h10] = 8'h05;
    mem[8'h11] = 8'h7F;
    mem[8'h12] = 8'hF0;
    mem[8'h13] = 8'h7F;
    mem[8'h00] = 8'hFE;
    mem[8'h01] = 8'h80;
    mem[8'h02] = 8'hFF;
    mem[8'hFE] = 8'h11;
    mem[8'hFF] = 8'h22;
    stream.ready = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("init");
    reset = 1'b1;

    // Mixed words with a tie on the maximum.
    run(8'h10, 8'd4, -1, 0, -1);
    check("t1_argmax_idx", 32'(argmax_idx), 32'h1);
    check("t1_argmax_val", 32'(argmax_val), 32'h7F);

    // All negative words: first word seeds the max.
    run(8'h00, 8'd3, -1, 0, -1);
    check("t2_argmax_idx", 32'(argmax_idx), 32'h2);
    check("t2_argmax_val", 32'(argmax_val), 32'hFF);

    // Empty result set.
    run(8'h40, 8'd0, -1, 0, -1);
    check("t3_argmax_val", 32'(argmax_val), 32'h80);

    // Address wrap.
    run(8'hFE, 8'd3, -1, 0, -1);
    check("t4_adr_count", 32'(seen_adr.size()), 32'd3);
    if (seen_adr.size() == 3) begin
      check("t4_adr0", 32'(seen_adr[0]), 32'hFE);
      check("t4_adr1", 32'(seen_adr[1]), 32'hFF);
      check("t4_adr2", 32'(seen_adr[2]), 32'h00);
    end
    check("t4_argmax_idx", 32'(argmax_idx), 32'h1);

    // Back-pressure on the second word for five cycles.
    run(8'h10, 8'd4, 1, 5, -1);
    check("t5_argmax_val", 32'(argmax_val), 32'h7F);

    // Reset during the hold of the second word, then a full clean run.
    run(8'h10, 8'd4, -1, 0, 1);
    run(8'h10, 8'd4, -1, 0, -1);
    check("t6_argmax_idx", 32'(argmax_idx), 32'h1);

    // Dropping finished leaves DONE.
    finished = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("done_clears", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
